fir_coef_cfg_ctrl: RTL
======================

// Module: fir_coef_cfg_ctrl
// PURPOSE
//  Configuration controller for the 4-tap FIR datapath. Receives coefficient frames over a
//  valid/ready byte stream and checks them. Holds them in a shadow buffer. Commits them to the
//  filter coefficient registers only on a sample boundary, so taps never change mid-sample.
//  Sits between the board-level config input and the FIR coefficient write port.
// PARAMETERS
//  NTAPS    4      number of coefficients per frame (coef_idx width = clog2(NTAPS))
//  CW       8      coefficient / config byte width
//  HDR      8'hA5  frame header byte
//  TIMEOUT  255    max idle cycles between bytes inside a frame before abort (>=1)
// PORTS
//  clk          in   1            clock, rising edge
//  reset        in   1            asynchronous, active-high reset
//  cfg_valid    in   1            config byte valid
//  cfg_data     in   CW           config byte
//  cfg_ready    out  1            controller accepts byte (transfer = cfg_valid & cfg_ready)
//  sample_tick  in   1            1-cycle pulse marking a FIR sample boundary
//  coef_we      out  1            coefficient write strobe to FIR
//  coef_idx     out  clog2(NTAPS) tap index written
//  coef_data    out  CW           coefficient value written
//  bank_swap    out  1            1-cycle pulse: new coefficient set complete
//  busy         out  1            high in any state other than IDLE
//  err          out  1            1-cycle pulse: checksum mismatch or timeout abort
// BEHAVIOUR
//  Reset: clk is reset by reset, which is asynchronous and active-high. All outputs are 0,
//   including cfg_ready, while reset is high. State goes to IDLE, counters and shadow regs clear.
//   The first cycle after release has cfg_ready=1.
//  States: IDLE -> LOAD -> CHECK -> WAIT_TICK -> WRITE -> IDLE.
//  IDLE: cfg_ready=1. A transfer with cfg_data==HDR goes to LOAD with idx=0. Any other byte is
//   consumed and dropped silently, with no err.
//  LOAD: cfg_ready=1. Each transfer stores the byte to shadow[idx] and XORs it into chk.
//   The transfer that fills idx==NTAPS-1 goes to CHECK. A HDR value here is data, not a restart.
//  CHECK: cfg_ready=1. The next transfer is compared with chk (XOR of all NTAPS coef bytes).
//   Equal: go to WAIT_TICK. Not equal: err=1 for the next cycle, shadow discarded, go to IDLE.
//  Timeout: in LOAD/CHECK a counter counts consecutive cycles without a transfer and clears on
//   each transfer. When it reaches TIMEOUT: err pulse, go to IDLE, partial frame discarded.
//  WAIT_TICK: cfg_ready=0 (bytes are held off, not lost). Wait for sample_tick=1.
//   A tick in the same cycle the checksum is accepted does not count; the next tick does.
//  WRITE: entered the cycle after the tick. Runs NTAPS consecutive cycles with coef_we=1,
//   coef_idx=0..NTAPS-1 and coef_data=shadow[idx]. bank_swap=1 in the cycle after the last
//   write. Return to IDLE in that same cycle. sample_tick is ignored during WRITE.
//  Latency: last-write-to-bank_swap = 1 cycle.
//   Tick-to-first-write = 1 cycle.
//  Outputs: coef_we, coef_idx, coef_data, bank_swap and err are registered.
//   coef_idx and coef_data are 0 whenever coef_we=0.
//  Reset mid-WRITE aborts immediately. Taps already written stay in the FIR (outside this block).
//   No bank_swap is issued.
//  err and bank_swap never assert in the same cycle.
// TESTING
//  1 Bytes A5,01,02,03,04,04, then a tick -> writes idx0..3 = 01,02,03,04 on consecutive cycles,
//    bank_swap 1 cycle later, err=0.
//  2 Bytes A5,01,02,03,04,05 (bad checksum) -> err pulse, no coef_we, cfg_ready=1, state IDLE.
//  3 Bytes 00,FF,A5 then a valid frame -> leading bytes ignored, frame committed as in test 1.
//  4 Bytes A5,01, then cfg_valid=0 for 255 cycles -> err pulse, back to IDLE.
//    A following good frame commits normally.
//  5 cfg_valid held high during WAIT_TICK with data 7E -> cfg_ready=0, byte not consumed.
//    After bank_swap, 7E is consumed in IDLE and dropped.
//  6 reset asserted after the idx1 write -> all outputs 0 immediately, no bank_swap.
//    After release: busy=0, cfg_ready=1.

Source files
------------

// File: rtl/fir_coef_cfg_ctrl_if.sv
// Config byte stream in, coefficient write port out, plus status strobes.
// Handshake: a byte moves on a rising clk edge where cfg_valid and cfg_ready are both 1;
// the master holds cfg_data stable while cfg_valid is high and cfg_ready is low.
interface fir_coef_cfg_ctrl_if #(
    parameter int NTAPS = 4,
    parameter int CW    = 8
);
    localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;

    logic          cfg_valid;
    logic [CW-1:0] cfg_data;
    logic          cfg_ready;
    logic          sample_tick;
    logic          coef_we;
    logic [IW-1:0] coef_idx;
    logic [CW-1:0] coef_data;
    logic          bank_swap;
    logic          busy;
    logic          err;

    modport master (
        output cfg_valid, cfg_data, sample_tick,
        input  cfg_ready, coef_we, coef_idx, coef_data, bank_swap, busy, err
    );

    modport slave (
        input  cfg_valid, cfg_data, sample_tick,
        output cfg_ready, coef_we, coef_idx, coef_data, bank_swap, busy, err
    );
endinterface

// File: rtl/fir_coef_cfg_ctrl.sv
// FIR coefficient configuration controller: receives a header + NTAPS coefficients +
// XOR checksum, buffers them in a shadow set, and writes them to the FIR taps only
// after a sample boundary so the taps never change in the middle of a sample.
module fir_coef_cfg_ctrl #(
    parameter int            NTAPS   = 4,
    parameter int            CW      = 8,
    parameter logic [CW-1:0] HDR     = 8'hA5,
    parameter int            TIMEOUT = 255
) (
    input  logic                      clk,
    input  logic                      reset,
    fir_coef_cfg_ctrl_if.slave        cfg_bus,
    output logic [2:0]                o_dbg_state
);
    localparam int IW = (NTAPS > 1) ? $clog2(NTAPS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LOAD      = 3'd1,
        S_CHECK     = 3'd2,
        S_WAIT_TICK = 3'd3,
        S_WRITE     = 3'd4
    } state_t;

    state_t        r_state, w_nxt_state;
    logic [IW-1:0] r_idx, w_nxt_idx, w_idx_inc;
    logic [CW-1:0] r_chk, w_nxt_chk;
    logic [TW-1:0] r_tmo, w_nxt_tmo;
    logic [CW-1:0] r_shadow [NTAPS];
    logic          r_coef_we, w_nxt_we;
    logic [IW-1:0] r_coef_idx, w_nxt_cidx;
    logic [CW-1:0] r_coef_data, w_nxt_cdata;
    logic          r_bank_swap, w_nxt_swap;
    logic          r_err, w_nxt_err;
    logic          w_ready, w_xfer, w_shadow_we, w_tmo_hit;

    // Ready only in the byte-accepting states, and forced low while reset is held.
    assign w_ready   = ~reset & ((r_state == S_IDLE) | (r_state == S_LOAD) | (r_state == S_CHECK));
    assign w_xfer    = cfg_bus.cfg_valid & w_ready;
    assign w_idx_inc = r_idx + 1'b1;
    // The idle counter reaches TIMEOUT on this cycle if no byte moves.
    assign w_tmo_hit = (r_tmo == TW'(TIMEOUT - 1));

    // Next-state and next-output logic; all registered outputs default to 0.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_idx   = r_idx;
        w_nxt_chk   = r_chk;
        w_nxt_tmo   = r_tmo;
        w_nxt_we    = 1'b0;
        w_nxt_cidx  = '0;
        w_nxt_cdata = '0;
        w_nxt_swap  = 1'b0;
        w_nxt_err   = 1'b0;
        w_shadow_we = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_xfer && cfg_bus.cfg_data == HDR) begin
                    w_nxt_state = S_LOAD;
                    w_nxt_idx   = '0;
                    w_nxt_chk   = '0;
                    w_nxt_tmo   = '0;
                end
            end
            S_LOAD: begin
                if (w_xfer) begin
                    w_shadow_we = 1'b1;
                    w_nxt_chk   = r_chk ^ cfg_bus.cfg_data;
                    w_nxt_tmo   = '0;
                    if (r_idx == IW'(NTAPS - 1)) w_nxt_state = S_CHECK;
                    else                         w_nxt_idx   = w_idx_inc;
                end else if (w_tmo_hit) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_err   = 1'b1;
                end else begin
                    w_nxt_tmo = r_tmo + 1'b1;
                end
            end
            S_CHECK: begin
                if (w_xfer) begin
                    w_nxt_tmo = '0;
                    if (cfg_bus.cfg_data == r_chk) begin
                        w_nxt_state = S_WAIT_TICK;
                    end else begin
                        w_nxt_state = S_IDLE;
                        w_nxt_err   = 1'b1;
                    end
                end else if (w_tmo_hit) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_err   = 1'b1;
                end else begin
                    w_nxt_tmo = r_tmo + 1'b1;
                end
            end
            S_WAIT_TICK: begin
                // First write is issued straight off the tick edge.
                if (cfg_bus.sample_tick) begin
                    w_nxt_state = S_WRITE;
                    w_nxt_idx   = '0;
                    w_nxt_we    = 1'b1;
                    w_nxt_cidx  = '0;
                    w_nxt_cdata = r_shadow[0];
                end
            end
            S_WRITE: begin
                // r_idx is the tap currently on the write port.
                if (r_idx == IW'(NTAPS - 1)) begin
                    w_nxt_state = S_IDLE;
                    w_nxt_swap  = 1'b1;
                end else begin
                    w_nxt_idx   = w_idx_inc;
                    w_nxt_we    = 1'b1;
                    w_nxt_cidx  = w_idx_inc;
                    w_nxt_cdata = r_shadow[w_idx_inc];
                end
            end
            default: w_nxt_state = S_IDLE;
        endcase
    end

    // State, counters, shadow buffer and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_chk       <= '0;
            r_tmo       <= '0;
            r_coef_we   <= 1'b0;
            r_coef_idx  <= '0;
            r_coef_data <= '0;
            r_bank_swap <= 1'b0;
            r_err       <= 1'b0;
            for (int i = 0; i < NTAPS; i++) r_shadow[i] <= '0;
        end else begin
            r_state     <= w_nxt_state;
            r_idx       <= w_nxt_idx;
            r_chk       <= w_nxt_chk;
            r_tmo       <= w_nxt_tmo;
            r_coef_we   <= w_nxt_we;
            r_coef_idx  <= w_nxt_cidx;
            r_coef_data <= w_nxt_cdata;
            r_bank_swap <= w_nxt_swap;
            r_err       <= w_nxt_err;
            if (w_shadow_we) r_shadow[r_idx] <= cfg_bus.cfg_data;
        end
    end

    assign cfg_bus.cfg_ready = w_ready;
    assign cfg_bus.coef_we   = r_coef_we;
    assign cfg_bus.coef_idx  = r_coef_idx;
    assign cfg_bus.coef_data = r_coef_data;
    assign cfg_bus.bank_swap = r_bank_swap;
    assign cfg_bus.err       = r_err;
    assign cfg_bus.busy      = (r_state != S_IDLE);
    assign o_dbg_state       = r_state;
endmodule
